// File: rtl/jam_cost_if.sv
//==============================================================================
// Module      : jam_cost_if
// Description : Cost-table load stream, assignment-engine lookup port and
//               table status, shared by the loader and its neighbours.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface jam_cost_if;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_ready;
    logic [2:0] W;
    logic [2:0] J;
    logic [6:0] Cost;
    logic       jam_rst;
    logic       jam_valid;
    logic       load_done;
    logic [9:0] LowerBound;

    modport master (
        output in_valid, in_data, W, J, jam_valid,
        input  in_ready, Cost, jam_rst, load_done, LowerBound
    );

    modport slave (
        input  in_valid, in_data, W, J, jam_valid,
        output in_ready, Cost, jam_rst, load_done, LowerBound
    );
endinterface

`default_nettype wire

// File: rtl/jam_cost_loader.sv
//==============================================================================
// Module      : jam_cost_loader
// Description : Loads an 8x8 table of 7-bit costs, computes the row-minimum
//               lower bound and serves costs to the assignment engine.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module jam_cost_loader (
    input  wire logic   CLK,
    input  wire logic   RST,
    jam_cost_if.slave   bus
);

    localparam logic [5:0] c_LAST_IDX = 6'd63;
    localparam logic [2:0] c_LAST_COL = 3'd7;
    localparam logic [2:0] c_FIRST_COL = 3'd0;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        SERVE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [5:0] r_idx;
    logic [6:0] r_row_min;
    logic [9:0] r_lb_acc;
    logic [9:0] r_lower_bound;
    logic       r_load_done;
    logic [6:0] r_mem [0:63];

    logic       w_accept;
    logic       w_in_ready;
    logic       w_jam_rst;
    logic       w_serve;
    logic [2:0] w_col;
    logic [6:0] w_min;
    logic [9:0] w_lb_sum;
    logic [6:0] w_cost;

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Next state and state-decoded outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_jam_rst   = 1'b1;
        w_serve     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            LOAD: begin
                w_in_ready = 1'b1;
                w_accept   = bus.in_valid;
                if (bus.in_valid && (r_idx == c_LAST_IDX)) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                // One cycle of engine reset before the table is served.
                w_state_nxt = SERVE;
            end
            SERVE: begin
                w_jam_rst = 1'b0;
                w_serve   = 1'b1;
                if (bus.jam_valid) begin
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Row minimum and lower-bound accumulation
    //--------------------------------------------------------------------------
    assign w_col    = r_idx[2:0];
    assign w_min    = ((w_col == c_FIRST_COL) || (bus.in_data < r_row_min))
                      ? bus.in_data : r_row_min;
    assign w_lb_sum = r_lb_acc + {3'b000, w_min};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_idx         <= '0;
            r_row_min     <= '0;
            r_lb_acc      <= '0;
            r_lower_bound <= '0;
            r_load_done   <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            if (w_accept) begin
                r_idx     <= r_idx + 6'd1;
                r_row_min <= w_min;
                if (r_idx == c_LAST_IDX) begin
                    r_lower_bound <= w_lb_sum;
                    r_lb_acc      <= '0;
                    r_load_done   <= 1'b1;
                end else if (w_col == c_LAST_COL) begin
                    r_lb_acc <= w_lb_sum;
                end
            end
        end
    end

    // Table storage carries no reset; it is only read once a full table exists.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_mem[r_idx] <= bus.in_data;
        end
    end

    assign w_cost = w_serve ? r_mem[{bus.W, bus.J}] : 7'd0;

    assign bus.in_ready   = w_in_ready;
    assign bus.jam_rst    = w_jam_rst;
    assign bus.Cost       = w_cost;
    assign bus.load_done  = r_load_done;
    assign bus.LowerBound = r_lower_bound;

endmodule

`default_nettype wire

// File: tb/tb_jam_cost_loader.sv
//==============================================================================
// Module      : tb_jam_cost_loader
// Description : Self-checking bench for jam_cost_loader.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_jam_cost_loader;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    jam_cost_if bus ();

    jam_cost_loader dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [6:0] tbl [64];
    logic [6:0] mdl [64];
    int         lb_q [$];
    logic [6:0] cost_q [$];
    int         exp_lb;
    logic [6:0] exp_cost;

    function automatic int model_lb();
        int s;
        int m;
        s = 0;
        for (int r = 0; r < 8; r++) begin
            m = 127;
            for (int c = 0; c < 8; c++) begin
                if (int'(tbl[r*8 + c]) < m) m = int'(tbl[r*8 + c]);
            end
            s += m;
        end
        return s;
    endfunction

    // Every completion pulse must match the next table pushed by the driver.
    always @(negedge CLK) begin
        if (!RST && bus.load_done === 1'b1) begin
            n_checks++;
            if (lb_q.size() == 0) begin
                n_errors++;
                $display("FAIL load_done_unexpected: got pulse, LowerBound=%0d, no table pending", bus.LowerBound);
            end else begin
                exp_lb = lb_q.pop_front();
                if (bus.LowerBound !== 10'(exp_lb)) begin
                    n_errors++;
                    $display("FAIL lower_bound: got %0d, expected %0d", bus.LowerBound, exp_lb);
                end
            end
        end
    end

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_table(input int first, input int last, input bit toggle, output int cycles);
        int k;
        k = first;
        cycles = 0;
        while (k <= last && cycles < 400) begin
            bus.in_valid = toggle ? (cycles % 2 == 0) : 1'b1;
            bus.in_data  = tbl[k];
            @(negedge CLK);
            if (bus.in_valid && bus.in_ready) begin
                if (k == 63) begin
                    for (int i = 0; i < 64; i++) mdl[i] = tbl[i];
                    lb_q.push_back(model_lb());
                end
                k++;
            end
            cycles++;
            sync();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (k != last + 1) begin
            n_errors++;
            $display("FAIL load_accepts: got %0d words, expected %0d", k - first, last - first + 1);
        end
    endtask

    task automatic lookup(input logic [2:0] w, input logic [2:0] j);
        bus.W = w;
        bus.J = j;
        cost_q.push_back(mdl[{w, j}]);
        #1;
        exp_cost = cost_q.pop_front();
        n_checks++;
        if (bus.Cost !== exp_cost) begin
            n_errors++;
            $display("FAIL cost(%0d,%0d): got %0d, expected %0d", w, j, bus.Cost, exp_cost);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic exit_serve();
        sync();
        bus.jam_valid = 1'b1;
        sync();
        bus.jam_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 RST = 1'b1;
        #1;
        check_bit("rst_in_ready", bus.in_ready, 1'b1);
        check_bit("rst_jam_rst", bus.jam_rst, 1'b1);
        check_bit("rst_load_done", bus.load_done, 1'b0);
        n_checks++;
        if (bus.Cost !== 7'd0 || bus.LowerBound !== 10'd0) begin
            n_errors++;
            $display("FAIL rst_outputs: Cost=%0d LowerBound=%0d, expected 0/0", bus.Cost, bus.LowerBound);
        end
        sync();
        RST = 1'b0;
    endtask

    task automatic test_stream();
        int cyc;
        for (int i = 0; i < 64; i++) tbl[i] = 7'(i);
        load_table(0, 63, 1'b0, cyc);
        n_checks++;
        if (cyc != 64) begin
            n_errors++;
            $display("FAIL stream_cycles: got %0d, expected 64", cyc);
        end
        bus.W = 3'd3;
        bus.J = 3'd5;
        @(negedge CLK);
        check_bit("start_jam_rst", bus.jam_rst, 1'b1);
        check_bit("start_in_ready", bus.in_ready, 1'b0);
        check_bit("start_load_done", bus.load_done, 1'b1);
        n_checks++;
        if (bus.Cost !== 7'd0) begin
            n_errors++;
            $display("FAIL start_cost: got %0d, expected 0", bus.Cost);
        end
        sync();
        @(negedge CLK);
        check_bit("serve_jam_rst", bus.jam_rst, 1'b0);
        check_bit("serve_load_done", bus.load_done, 1'b0);
        n_checks++;
        if (bus.LowerBound !== 10'd224 || lb_q.size() != 0) begin
            n_errors++;
            $display("FAIL stream_lb: got %0d, expected 224 (pending %0d)", bus.LowerBound, lb_q.size());
        end
    endtask

    task automatic test_serve();
        sync();
        lookup(3'd3, 3'd5);
        lookup(3'd7, 3'd7);
        lookup(3'd0, 3'd0);
        sync();
        for (int i = 0; i < 4; i++) lookup(3'($urandom_range(7)), 3'($urandom_range(7)));
    endtask

    task automatic test_serve_ignore();
        sync();
        bus.in_valid = 1'b1;
        bus.in_data  = 7'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_bit("serve_in_ready", bus.in_ready, 1'b0);
            sync();
        end
        bus.in_valid = 1'b0;
        check_bit("serve_stays", bus.jam_rst, 1'b0);
        lookup(3'd0, 3'd0);
        lookup(3'd0, 3'd1);
    endtask

    task automatic test_jam_valid();
        bus.W = 3'd7;
        bus.J = 3'd7;
        exit_serve();
        @(negedge CLK);
        check_bit("jv_in_ready", bus.in_ready, 1'b1);
        check_bit("jv_jam_rst", bus.jam_rst, 1'b1);
        n_checks++;
        if (bus.Cost !== 7'd0) begin
            n_errors++;
            $display("FAIL jv_cost: got %0d, expected 0", bus.Cost);
        end
    endtask

    task automatic test_saturate();
        int cyc;
        sync();
        for (int i = 0; i < 64; i++) tbl[i] = 7'd127;
        bus.jam_valid = 1'b1;
        load_table(0, 63, 1'b0, cyc);
        sync();
        bus.jam_valid = 1'b0;
        @(negedge CLK);
        check_bit("sat_serve_after_start", bus.jam_rst, 1'b0);
        n_checks++;
        if (bus.LowerBound !== 10'd1016) begin
            n_errors++;
            $display("FAIL sat_lb: got %0d, expected 1016", bus.LowerBound);
        end
        lookup(3'd4, 3'd2);
        exit_serve();
        for (int i = 0; i < 64; i++) tbl[i] = 7'd0;
        load_table(0, 62, 1'b0, cyc);
        @(negedge CLK);
        n_checks++;
        if (bus.LowerBound !== 10'd1016) begin
            n_errors++;
            $display("FAIL partial_lb_hold: got %0d, expected 1016", bus.LowerBound);
        end
        sync();
        load_table(63, 63, 1'b0, cyc);
        @(negedge CLK);
        n_checks++;
        if (bus.LowerBound !== 10'd0) begin
            n_errors++;
            $display("FAIL zero_lb: got %0d, expected 0", bus.LowerBound);
        end
        sync();
    endtask

    task automatic test_toggle();
        int cyc;
        exit_serve();
        for (int i = 0; i < 64; i++) tbl[i] = 7'($urandom_range(127));
        load_table(0, 63, 1'b1, cyc);
        n_checks++;
        if (cyc != 127) begin
            n_errors++;
            $display("FAIL toggle_cycles: got %0d, expected 127", cyc);
        end
        sync();
        for (int i = 0; i < 3; i++) lookup(3'($urandom_range(7)), 3'($urandom_range(7)));
    endtask

    task automatic test_reset_midload();
        int cyc;
        exit_serve();
        for (int i = 0; i < 64; i++) tbl[i] = 7'($urandom_range(127));
        load_table(0, 19, 1'b0, cyc);
        RST = 1'b1;
        #2;
        check_bit("midrst_in_ready", bus.in_ready, 1'b1);
        n_checks++;
        if (bus.LowerBound !== 10'd0) begin
            n_errors++;
            $display("FAIL midrst_lb: got %0d, expected 0", bus.LowerBound);
        end
        sync();
        RST = 1'b0;
        for (int i = 0; i < 64; i++) tbl[i] = 7'($urandom_range(1, 127));
        tbl[0] = 7'd99;
        load_table(0, 63, 1'b0, cyc);
        sync();
        lookup(3'd0, 3'd0);
        lookup(3'd0, 3'd7);
        lookup(3'd5, 3'd3);
    endtask

    task automatic test_reset_serve();
        bus.W = 3'd0;
        bus.J = 3'd0;
        sync();
        RST = 1'b1;
        #1;
        check_bit("srst_jam_rst", bus.jam_rst, 1'b1);
        check_bit("srst_in_ready", bus.in_ready, 1'b1);
        sync();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_checks++;
            if (bus.jam_rst !== 1'b1 || bus.Cost !== 7'd0) begin
                n_errors++;
                $display("FAIL srst_no_reserve: jam_rst=%b Cost=%0d, expected 1/0", bus.jam_rst, bus.Cost);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.W         = '0;
        bus.J         = '0;
        bus.jam_valid = 1'b0;
        test_reset();
        test_stream();
        test_serve();
        test_serve_ignore();
        test_jam_valid();
        test_saturate();
        test_toggle();
        test_reset_midload();
        test_reset_serve();
        n_checks++;
        if (lb_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_tables: got %0d unacknowledged, expected 0", lb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/jam_cost_loader.md
JAM_COST_LOADER -- requirements
Module: jam_cost_loader

Interface
REQ-001 The block SHALL have no parameters; the table dimensions SHALL be fixed at 8 workers x 8 jobs, 7-bit costs.
REQ-002 CLK  input  1  clock; all state SHALL change on the rising edge only.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  the upstream cost word on in_data is valid.
REQ-005 in_data  input  7  cost word, row-major order (worker-major, job-minor).
REQ-006 in_ready  output  1  the block accepts in_data this cycle.
REQ-007 W  input  3  worker index from the downstream assignment engine.
REQ-008 J  input  3  job index from the downstream assignment engine.
REQ-009 Cost  output  7  cost of entry (W,J), driven to the assignment engine.
REQ-010 jam_rst  output  1  active-high reset, held on the assignment engine while its table is invalid.
REQ-011 jam_valid  input  1  result-valid flag from the assignment engine.
REQ-012 load_done  output  1  one-cycle pulse when a complete table has been accepted.
REQ-013 LowerBound  output  10  sum of the eight row minima of the last complete table.

Function
REQ-014 States SHALL be LOAD, START and SERVE, encoded in a registered state variable.
REQ-015 Handshake: a word SHALL be accepted exactly on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LOAD.
REQ-016 Write path: an accepted word SHALL be written to mem[idx], where idx is a 6-bit counter = {row,col}; idx SHALL increment by 1 per accept.
REQ-017 Row minimum: row_min SHALL take the data value on col=0 and min(row_min, data) on col=1..7.
REQ-018 Bound accumulation: on col=7, lb_acc SHALL add min(row_min, data); lb_acc SHALL be 10 bits wide, with a maximum value of 8*127=1016, so it never overflows.
REQ-019 Table completion: on the accept with idx=63, the block SHALL register LowerBound = final lb_acc, pulse load_done for exactly the next cycle, clear idx and lb_acc, and go to START.
REQ-020 START SHALL last exactly one cycle with jam_rst=1, then go to SERVE.
REQ-021 jam_rst SHALL be 1 in LOAD and START, and 0 in SERVE, so the assignment engine runs from its reset values on the first SERVE cycle.
REQ-022 In SERVE, Cost SHALL equal mem[{W,J}] combinationally, with zero-cycle latency, in the same cycle W/J change.
REQ-023 Outside SERVE, Cost SHALL be 0.
REQ-024 In SERVE, when jam_valid=1 is sampled, the block SHALL go to LOAD on the next edge, raising jam_rst and in_ready and clearing the engine's result.
REQ-025 jam_valid SHALL be ignored in LOAD and START.
REQ-026 in_valid SHALL be ignored in START and SERVE, and no write SHALL occur.
REQ-027 LowerBound SHALL hold its value until the next table completes; it SHALL not change during a partial reload.
REQ-028 mem SHALL need no reset; entries of a partially loaded table SHALL never be served.
REQ-029 A sustained in_valid=1 SHALL load a full table in 64 consecutive cycles, with no bubbles.

Reset
REQ-030 On RST=1, independent of CLK, the block SHALL go to LOAD with idx=0, row_min=0, lb_acc=0, LowerBound=0, load_done=0, jam_rst=1, in_ready=1 and Cost=0.
REQ-031 RST asserted mid-load SHALL discard the partial table: after release, the next accepted word SHALL be written to idx 0.
REQ-032 RST asserted in SERVE SHALL return the block to LOAD with jam_rst=1, and the block SHALL not re-serve the old table.

Verification
REQ-033 Stream 0..63 (value = idx mod 128) with in_valid held high -> load_done pulses one cycle after the 64th accept; LowerBound = 0+8+16+...+56 = 224; jam_rst falls 2 cycles after the last accept.
REQ-034 Same table, SERVE, W=3, J=5 -> Cost=29 in the same cycle; W=7, J=7 -> Cost=63.
REQ-035 All 64 words = 127 -> LowerBound = 1016, with no wrap; a second table of all 0s -> LowerBound = 0 only after its 64th accept, and 1016 held until then.
REQ-036 in_valid toggled 1/0 every cycle -> exactly 64 accepts over 127 cycles; in_valid asserted during SERVE -> no write and in_ready=0.
REQ-037 RST pulsed after 20 accepts, then a full table streamed -> LowerBound computed from the new table only, and the first new word appears at mem[0].
REQ-038 jam_valid raised in SERVE -> next cycle state=LOAD, jam_rst=1, in_ready=1, Cost=0; jam_valid raised during LOAD -> no effect.
